// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - control FSM for the 16-bit subtractive GCD datapath (optional iter_count port: GCD_ITER_COUNT_EN)
module gcd_controller #(
   parameter int MAX_ITER = 65535,
   parameter int ITER_W   = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic lt,
   input  logic gt,
   input  logic eq,
   output logic ldA,
   output logic ldB,
   output logic sel1,
   output logic sel2,
   output logic sel_in,
   output logic busy,
   output logic done,
   output logic err
`ifdef GCD_ITER_COUNT_EN
   ,
   output logic [ITER_W-1:0] iter_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_CMP    = 3'd3,
      S_SUB_A  = 3'd4,
      S_SUB_B  = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

   state_t            state;
   state_t            state_nxt;
   logic [ITER_W-1:0] iter_cnt;
   logic              at_max;
   logic              in_sub;

   assign at_max = (iter_cnt == ITER_MAX);
   assign in_sub = (state == S_SUB_A) || (state == S_SUB_B);

   // State register; reset abandons any in-flight computation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Iteration counter: cleared when operand B loads, counts subtractions, saturates at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         iter_cnt <= '0;
      end else if (state == S_LOAD_B) begin
         iter_cnt <= '0;
      end else if (in_sub && !at_max) begin
         iter_cnt <= iter_cnt + 1'b1;
      end
   end

   // Next-state logic; compare priority is eq, limit, gt, lt, with no flag at all treated as a fault.
   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE:   state_nxt = start ? S_LOAD_A : S_IDLE;
         S_LOAD_A: state_nxt = S_LOAD_B;
         S_LOAD_B: state_nxt = S_CMP;
         S_CMP: begin
            if (eq) begin
               state_nxt = S_DONE;
            end else if (at_max) begin
               state_nxt = S_ERR;
            end else if (gt) begin
               state_nxt = S_SUB_A;
            end else if (lt) begin
               state_nxt = S_SUB_B;
            end else begin
               state_nxt = S_ERR;
            end
         end
         S_SUB_A:  state_nxt = S_CMP;
         S_SUB_B:  state_nxt = S_CMP;
         S_DONE:   state_nxt = start ? S_LOAD_A : S_DONE;
         S_ERR:    state_nxt = start ? S_LOAD_A : S_ERR;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Moore output decode from the state register only.
   always_comb begin
      ldA    = 1'b0;
      ldB    = 1'b0;
      sel1   = 1'b0;
      sel2   = 1'b0;
      sel_in = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      err    = 1'b0;
      case (state)
         S_LOAD_A: begin
            ldA    = 1'b1;
            sel_in = 1'b1;
            busy   = 1'b1;
         end
         S_LOAD_B: begin
            ldB    = 1'b1;
            sel_in = 1'b1;
            busy   = 1'b1;
         end
         S_CMP: begin
            busy = 1'b1;
         end
         S_SUB_A: begin
            ldA  = 1'b1;
            sel2 = 1'b1;
            busy = 1'b1;
         end
         S_SUB_B: begin
            ldB  = 1'b1;
            sel1 = 1'b1;
            busy = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         S_ERR: begin
            err = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

`ifdef GCD_ITER_COUNT_EN
   assign iter_count = iter_cnt;
`endif

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- Control FSM for the 16-bit subtractive GCD datapath: two load-enabled PIPO operand registers (A, B), subtractor, magnitude comparator and input/operand muxes.
- Sequences operand loads from the shared data_in bus, consumes the comparator's lt/gt/eq flags, and steers the subtract-and-reload loop until A == B.
- Reports completion, or an error on iteration overflow, e.g. a zero operand that never converges.

Parameters:
- MAX_ITER, 65535, maximum subtraction steps before abort; must be >= 1.
- ITER_W, 16, width of the internal iteration counter; must hold MAX_ITER.

Ports:
- clk  input  1  rising-edge clock, shared with the datapath.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new computation; sampled only in IDLE, DONE and ERR.
- lt  input  1  comparator: A < B.
- gt  input  1  comparator: A > B.
- eq  input  1  comparator: A == B.
- ldA  output  1  load enable, A register.
- ldB  output  1  load enable, B register.
- sel1  output  1  subtractor minuend mux: 0 = A, 1 = B.
- sel2  output  1  subtractor subtrahend mux: 0 = A, 1 = B.
- sel_in  output  1  register input mux: 1 = data_in, 0 = subtractor output.
- busy  output  1  high from LOAD_A through the final CMP.
- done  output  1  result valid; A and B both hold the GCD.
- err  output  1  iteration limit hit; A and B contents undefined.

Behaviour:
- Reset: rst high at a clock edge forces IDLE and clears the iteration counter. Applies mid-operation as well; the in-flight computation is abandoned.
- Output defaults: all outputs are 0 in IDLE and immediately after reset.
- Output style: Moore. Outputs are decoded from the state register only and never depend combinationally on lt/gt/eq or start.
- IDLE: if start = 1, go to LOAD_A; otherwise stay.
- LOAD_A: ldA = 1, sel_in = 1, busy = 1. The external source drives operand A on data_in during this cycle. Always goes to LOAD_B.
- LOAD_B: ldB = 1, sel_in = 1, busy = 1. Operand B is on data_in. Clears the iteration counter. Always goes to CMP.
- CMP: busy = 1, no loads. Flags are valid because the registers updated at the previous edge. Priority: eq, then counter == MAX_ITER, then gt, then lt.
  - eq -> DONE
  - counter == MAX_ITER -> ERR
  - gt -> SUB_A
  - lt -> SUB_B
- Illegal flag combinations (none set, or more than one set) are treated by the same priority order; the bench must not rely on this.
- SUB_A: ldA = 1, sel_in = 0, sel1 = 0, sel2 = 1 (A <= A - B). Counter increments. Goes to CMP.
- SUB_B: ldB = 1, sel_in = 0, sel1 = 1, sel2 = 0 (B <= B - A). Counter increments. Goes to CMP.
- DONE: done = 1, held as a level. start = 1 goes to LOAD_A (done drops the next cycle); otherwise stay.
- ERR: err = 1, held as a level. start = 1 goes to LOAD_A; otherwise stay.
- Busy period: start is ignored from LOAD_A through CMP; there is no abort other than rst.
- Latency: start sampled in cycle 0 gives LOAD_A in cycle 1, LOAD_B in cycle 2, first CMP in cycle 3. done rises in cycle 4 + 2*N, where N is the number of subtractions.
- Counter: saturates at MAX_ITER and never wraps.
- Zero operand: A = 0 or B = 0 with the other nonzero loops with no change, because X - 0 = X. This is terminated by ERR after MAX_ITER subtractions. A = B = 0 gives eq, so DONE with result 0.
- State encoding: unused encodings return to IDLE on the next clock.

Optional Feature:
- Macro: GCD_ITER_COUNT_EN.
- Defined: adds output port iter_count [ITER_W-1:0], equal to the internal counter. It is valid and stable in DONE and ERR, and 0 in IDLE and after reset.
- Undefined: port absent. The counter still exists internally for the timeout; all other behaviour is identical.

Test Plan:
- A = 12, B = 8 via data_in: SUB_A (A = 4), then SUB_B (B = 4), then eq. done rises in cycle 8 after start; ldA/ldB pulse exactly once each per subtraction; iter_count = 2 when enabled.
- A = 7, B = 7: no subtraction; done rises in cycle 4; sel_in = 1 only in cycles 1 and 2.
- MAX_ITER = 8, A = 5, B = 0: eight SUB_A cycles, then err = 1 in cycle 4 + 16 = 20 with done = 0; the next start recovers to LOAD_A.
- A = 65535, B = 1 with default parameters: 65534 SUB_A steps and no ERR; done asserts with A = B = 1.
- rst asserted in the third SUB cycle of A = 21, B = 6: all outputs 0 the next cycle and state IDLE; a new start with 9, 6 gives done with result 3.
- start held high in DONE: immediate relaunch (LOAD_A next cycle). start pulses during busy are ignored, with no extra loads observed.
